parking: RTL and testbench

- Car-park occupancy counter driven by two optical beam sensors across one entry/exit lane.
- Sensor `a` is the outer beam (street side) and `b` is the inner beam (lot side). An asserted bit means the beam is blocked.
- A car passing fully inward (a, then a+b, then b, then clear) increments `count`; the reverse sequence decrements it.
- Sits between the raw sensor pins and the display/gate controller.

---
 rtl/parking_pkg.sv | 22 ++
 rtl/sync_ff.sv | 26 ++
 rtl/parking.sv | 146 ++++++++++++++
 tb/tb_parking.sv | 136 +++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the car-park occupancy counter.
package parking_pkg;

   // Passage-tracking states: EN* walk an inward car, EX* an outward one.
   typedef enum logic [2:0] {
      IDLE,
      EN1,
      EN2,
      EN3,
      EX1,
      EX2,
      EX3,
      ERR
   } state_t;

   // Synchronized sensor codes, packed as {outer, inner}; 1 = beam blocked.
   localparam logic [1:0] CLEAR = 2'b00;
   localparam logic [1:0] OUTER = 2'b10;
   localparam logic [1:0] BOTH  = 2'b11;
   localparam logic [1:0] INNER = 2'b01;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage single-bit synchronizer with asynchronous active-low clear.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw input through the flop chain; the last stage is safe to use.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour, giving a real shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/parking.sv
// Car-park occupancy counter: tracks beam sequences on one lane and keeps a
// saturating count of cars inside.
module parking
   import parking_pkg::*;
#(
   parameter int MAX_COUNT   = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   output logic [7:0] count,
   output logic       full,
   output logic       empty
);

   localparam logic [7:0] COUNT_MAX = 8'(MAX_COUNT);

   logic       as;
   logic       bs;
   logic [1:0] code;
   state_t     state;
   state_t     next;
   logic       inc;
   logic       dec;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk   (clk),
      .rst_n (reset),
      .d     (a),
      .q     (as)
   );

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk   (clk),
      .rst_n (reset),
      .d     (b),
      .q     (bs)
   );

   assign code = {as, bs};

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   // Next-state decode; a completed passage pulses inc or dec for one cycle.
   // NOTE: every output gets a default before the case so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      next = state;
      inc  = 1'b0;
      dec  = 1'b0;
      unique case (state)
         IDLE: begin
            unique case (code)
               OUTER:   next = EN1;
               INNER:   next = EX1;
               BOTH:    next = ERR;
               default: next = IDLE;
            endcase
         end
         EN1: begin
            unique case (code)
               BOTH:    next = EN2;
               CLEAR:   next = IDLE;
               INNER:   next = ERR;
               default: next = EN1;
            endcase
         end
         EN2: begin
            unique case (code)
               INNER:   next = EN3;
               OUTER:   next = EN1;
               CLEAR:   next = ERR;
               default: next = EN2;
            endcase
         end
         EN3: begin
            unique case (code)
               CLEAR: begin
                  next = IDLE;
                  inc  = 1'b1;
               end
               BOTH:    next = EN2;
               OUTER:   next = ERR;
               default: next = EN3;
            endcase
         end
         EX1: begin
            unique case (code)
               BOTH:    next = EX2;
               CLEAR:   next = IDLE;
               OUTER:   next = ERR;
               default: next = EX1;
            endcase
         end
         EX2: begin
            unique case (code)
               OUTER:   next = EX3;
               INNER:   next = EX1;
               CLEAR:   next = ERR;
               default: next = EX2;
            endcase
         end
         EX3: begin
            unique case (code)
               CLEAR: begin
                  next = IDLE;
                  dec  = 1'b1;
               end
               BOTH:    next = EX2;
               INNER:   next = ERR;
               default: next = EX3;
            endcase
         end
         ERR: begin
            if (code == CLEAR) begin
               next = IDLE;
            end
         end
         default: next = IDLE;
      endcase
   end

   // Occupancy register, saturating at both ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != COUNT_MAX)) begin
         count <= count + 8'd1;
      end else if (dec && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign full  = (count == COUNT_MAX);
   assign empty = (count == 8'd0);

endmodule

// File: tb/tb_parking.sv
// Directed bench for parking: a default-capacity instance and a capacity-3
// instance share the same sensor stimulus and are checked side by side.
module tb_parking;

   logic       clk;
   logic       reset;
   logic       a;
   logic       b;
   logic [7:0] count_big;
   logic       full_big;
   logic       empty_big;
   logic [7:0] count_small;
   logic       full_small;
   logic       empty_small;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0] code;
      logic [7:0] exp_big;
      logic [7:0] exp_small;
   } vec_t;

   vec_t vecs[$];

   parking dut_big (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .count (count_big),
      .full  (full_big),
      .empty (empty_big)
   );

   parking #(.MAX_COUNT(3)) dut_small (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .count (count_small),
      .full  (full_small),
      .empty (empty_small)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] eb, input logic [7:0] es);
      check({tag, " count_big"},   count_big,         eb);
      check({tag, " full_big"},    {7'd0, full_big},    {7'd0, eb == 8'd255});
      check({tag, " empty_big"},   {7'd0, empty_big},   {7'd0, eb == 8'd0});
      check({tag, " count_small"}, count_small,       es);
      check({tag, " full_small"},  {7'd0, full_small},  {7'd0, es == 8'd3});
      check({tag, " empty_small"}, {7'd0, empty_small}, {7'd0, es == 8'd0});
   endtask

   // Appends n codes (first code in the most significant pair). Counts change
   // only on the last row: the final 00 sits two rows before the end, and the
   // third rising edge after it lands just before that row is sampled.
   task automatic add_seq(input logic [15:0] codes, input int n,
                          input logic [7:0] pre_b, input logic [7:0] pre_s,
                          input logic [7:0] post_b, input logic [7:0] post_s);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.code      = codes[2*(n-1-i) +: 2];
         v.exp_big   = (i == n-1) ? post_b : pre_b;
         v.exp_small = (i == n-1) ? post_s : pre_s;
         vecs.push_back(v);
      end
   endtask

   task automatic drive(input logic [1:0] code);
      {a, b} = code;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      a     = 1'b0;
      b     = 1'b0;

      // Full entry, exit, exit at zero, abort, backtrack, invalid, valid entry,
      // two entries into saturation of the small lot, then one exit.
      add_seq(16'b00_10_11_01_00_00_00,    7, 8'd0, 8'd0, 8'd1, 8'd1);
      add_seq(16'b01_11_10_00_00_00,       6, 8'd1, 8'd1, 8'd0, 8'd0);
      add_seq(16'b01_11_10_00_00_00,       6, 8'd0, 8'd0, 8'd0, 8'd0);
      add_seq(16'b10_00_00_00,             4, 8'd0, 8'd0, 8'd0, 8'd0);
      add_seq(16'b10_11_10_11_01_00_00_00, 8, 8'd0, 8'd0, 8'd1, 8'd1);
      add_seq(16'b11_01_00_00_00,          5, 8'd1, 8'd1, 8'd1, 8'd1);
      add_seq(16'b10_11_01_00_00_00,       6, 8'd1, 8'd1, 8'd2, 8'd2);
      add_seq(16'b10_11_01_00_00_00,       6, 8'd2, 8'd2, 8'd3, 8'd3);
      add_seq(16'b10_11_01_00_00_00,       6, 8'd3, 8'd3, 8'd4, 8'd3);
      add_seq(16'b01_11_10_00_00_00,       6, 8'd4, 8'd3, 8'd3, 8'd2);

      // Reset held low for three cycles.
      repeat (3) @(negedge clk);
      check_all("in_reset", 8'd0, 8'd0);
      reset = 1'b1;
      @(negedge clk);
      check_all("after_reset", 8'd0, 8'd0);

      // Table: one code per clock, sampled on the falling edge.
      foreach (vecs[i]) begin
         drive(vecs[i].code);
         check_all($sformatf("row%0d", i), vecs[i].exp_big, vecs[i].exp_small);
      end

      // Reset asserted while an entry is parked in EN2 must clear immediately.
      drive(2'b10);
      {a, b} = 2'b11;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1 check_all("mid_reset", 8'd0, 8'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(2'b11);
      drive(2'b01);
      drive(2'b00);
      repeat (4) @(negedge clk);
      check_all("after_mid_reset", 8'd0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
